// File: rtl/percept_pkg.sv
// percept_pkg: shared state encoding and default frame parameters for the percept link
package percept_pkg;

    localparam int PERCEPT_PAYLOAD_BITS = 129;
    localparam int PERCEPT_IDLE_GAP     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_GAP,
        ST_PAYLOAD,
        ST_GUARD
    } percept_state_e;

    function automatic int percept_nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/percept_tx_shifter.sv
// percept_tx_shifter: one-byte payload holding buffer feeding the MSB-first payload shifter
module percept_tx_shifter
    import percept_pkg::*;
#(
    parameter int PAYLOAD_BITS = PERCEPT_PAYLOAD_BITS
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       accept_en_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       pay_valid_i,
    input  logic [7:0] pay_data_i,
    input  logic       clr_underrun_i,
    output logic       pay_ready_o,
    output logic       bit_o,
    output logic       underrun_o
);

    localparam int NBYTES = percept_nbytes(PAYLOAD_BITS);
    localparam int CW     = $clog2(NBYTES + 1);

    logic [7:0]    buf_q, buf_d, sh_q, sh_d;
    logic          full_q, full_d, unr_q, unr_d, take;
    logic [CW-1:0] cnt_q, cnt_d;

    assign pay_ready_o = accept_en_i && !full_q && (cnt_q < CW'(NBYTES));
    assign take        = pay_valid_i && pay_ready_o;
    assign bit_o       = load_i ? (full_q & buf_q[7]) : sh_q[7];
    assign underrun_o  = unr_q;

    // A load drains the buffer (zeros if empty) into the shifter; a new byte may land the same cycle
    always_comb begin
        buf_d  = take ? pay_data_i : buf_q;
        full_d = clear_i ? 1'b0 : take ? 1'b1 : load_i ? 1'b0 : full_q;
        cnt_d  = clear_i ? '0 : take ? cnt_q + CW'(1) : cnt_q;
        sh_d   = load_i ? (full_q ? {buf_q[6:0], 1'b0} : 8'h00) : {sh_q[6:0], 1'b0};
        unr_d  = (load_i && !full_q) || (unr_q && !clr_underrun_i);
    end

    // Buffer, shifter, byte count and sticky underrun registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            buf_q  <= '0;
            sh_q   <= '0;
            full_q <= 1'b0;
            cnt_q  <= '0;
            unr_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            sh_q   <= sh_d;
            full_q <= full_d;
            cnt_q  <= cnt_d;
            unr_q  <= unr_d;
        end
    end

endmodule

// File: rtl/percept_tx.sv
// percept_tx: framed serial transmitter - start bit, 8-bit address, gap, payload, guard
module percept_tx
    import percept_pkg::*;
#(
    parameter int PAYLOAD_BITS = PERCEPT_PAYLOAD_BITS,
    parameter int IDLE_GAP     = PERCEPT_IDLE_GAP
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       req_valid,
    input  logic [7:0] req_addr,
    output logic       req_ready,
    input  logic       pay_valid,
    input  logic [7:0] pay_data,
    output logic       pay_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       underrun,
    input  logic       clr_underrun
);

    localparam int BW = (PAYLOAD_BITS > 8) ? $clog2(PAYLOAD_BITS) : 3;
    localparam int GW = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;

    percept_state_e state_q, state_d;
    logic [7:0]     addr_q, addr_d;
    logic [2:0]     abit_q, abit_d;
    logic [BW-1:0]  pbit_q, pbit_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic           load, clear, accept_en, pay_bit;

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = !req_ready;
    assign accept_en  = busy && (state_q != ST_GUARD);
    assign load       = (state_q == ST_PAYLOAD) && (pbit_q[2:0] == 3'd0);
    assign clear      = (state_q == ST_PAYLOAD) && (state_d == ST_GUARD);
    assign serial_out = (state_q == ST_START)   ? 1'b0 :
                        (state_q == ST_ADDR)    ? addr_q[3'd7 - abit_q] :
                        (state_q == ST_PAYLOAD) ? pay_bit : 1'b1;

    percept_tx_shifter #(
        .PAYLOAD_BITS(PAYLOAD_BITS)
    ) u_shifter (
        .clk           (clk),
        .nRst          (nRst),
        .accept_en_i   (accept_en),
        .clear_i       (clear),
        .load_i        (load),
        .pay_valid_i   (pay_valid),
        .pay_data_i    (pay_data),
        .clr_underrun_i(clr_underrun),
        .pay_ready_o   (pay_ready),
        .bit_o         (pay_bit),
        .underrun_o    (underrun)
    );

    // Frame sequencing; counters return to zero whenever their phase ends
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        abit_d  = '0;
        pbit_d  = '0;
        gcnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_START;
                    addr_d  = req_addr;
                end
            end
            ST_START: state_d = ST_ADDR;
            ST_ADDR: begin
                abit_d  = abit_q + 3'd1;
                state_d = (abit_q == 3'd7) ? ST_GAP : ST_ADDR;
            end
            ST_GAP: state_d = ST_PAYLOAD;
            ST_PAYLOAD: begin
                pbit_d  = (pbit_q == BW'(PAYLOAD_BITS - 1)) ? '0 : pbit_q + BW'(1);
                state_d = (pbit_q == BW'(PAYLOAD_BITS - 1)) ? ST_GUARD : ST_PAYLOAD;
            end
            ST_GUARD: begin
                gcnt_d  = (gcnt_q == GW'(IDLE_GAP - 1)) ? '0 : gcnt_q + GW'(1);
                state_d = (gcnt_q == GW'(IDLE_GAP - 1)) ? ST_IDLE : ST_GUARD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and frame counters; reset drops the frame immediately
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            abit_q  <= '0;
            pbit_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            abit_q  <= abit_d;
            pbit_q  <= pbit_d;
            gcnt_q  <= gcnt_d;
        end
    end

endmodule

// File: tb/tb_percept_tx.sv
// tb_percept_tx: randomized directed frames checked against a slot-level payload model
module tb_percept_tx;

    localparam int PB = 129;
    localparam int NB = 17;
    localparam int GAP = 2;
    localparam int FL = 10 + PB + GAP;

    logic clk = 1'b0, nRst = 1'b0, req_valid = 1'b0, pay_valid = 1'b0, clr_underrun = 1'b0;
    logic [7:0] req_addr = 8'h00, pay_data = 8'h00;
    logic req_ready, pay_ready, serial_out, busy, underrun;
    int nchk = 0, npass = 0, nfail = 0;
    logic [7:0] pay_q[$];
    int take_t[$];
    logic [7:0] take_b[$];

    percept_tx #(.PAYLOAD_BITS(PB), .IDLE_GAP(GAP)) dut (
        .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready), .serial_out(serial_out),
        .busy(busy), .underrun(underrun), .clr_underrun(clr_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted bytes fill payload slots in arrival order; a slot whose load cycle comes
    // before the next byte has arrived goes out as zeros.
    function automatic void model(output logic [PB-1:0] pay, output logic [NB-1:0] emp);
        int p;
        logic [7:0] b;
        p = 0;
        pay = '0;
        emp = '0;
        for (int j = 0; j < NB; j++) begin
            b = 8'h00;
            emp[j] = !(p < take_t.size() && take_t[p] < 10 + 8 * j);
            if (!emp[j]) begin
                b = take_b[p];
                p++;
            end
            for (int k = 0; k < 8; k++)
                if (8 * j + k < PB) pay[PB - 1 - (8 * j + k)] = b[7 - k];
        end
    endfunction

    task automatic fill(input int n);
        pay_q.delete();
        repeat (n) pay_q.push_back(8'($urandom));
    endtask

    task automatic start(input logic [7:0] a);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = a;
    endtask

    task automatic clear_unr(input string tag);
        @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk(tag, underrun, 0);
    endtask

    task automatic run_frame(input logic [7:0] addr, input int hold_idx, input int hold_t, input int jit,
                             input int clr_t, input int abort_t, input bit keep, input string tag,
                             output logic [FL:0] so_o);
        logic [FL:0] so, rr, bz, e_so, e_rr, e_bz;
        logic [PB-1:0] pay;
        logic [NB-1:0] emp;
        logic unr_end, exp_unr;
        int idx, ready_at, pr_bad;
        idx = 0;
        ready_at = 0;
        pr_bad = 0;
        unr_end = 1'b0;
        take_t.delete();
        take_b.delete();
        for (int t = 0; t <= FL; t++) begin
            @(negedge clk);
            so[t] = serial_out;
            rr[t] = req_ready;
            bz[t] = busy;
            if (t == FL) unr_end = underrun;
            if (t >= 10 + PB && pay_ready) pr_bad++;
            if (!keep) req_valid = 1'b0;
            else req_addr = 8'($urandom);
            if (clr_t >= 0 && t == clr_t + 1) begin
                model(pay, emp);
                chk({tag, " underrun_set_wins"}, underrun, emp[(clr_t - 10) / 8]);
            end
            if (t == abort_t) begin
                chk({tag, " pre_abort_bit"}, serial_out, 0);
                nRst = 1'b0;
                #1;
                chk({tag, " abort_outputs"}, {serial_out, busy, pay_ready, underrun}, 4'b1000);
                req_valid = 1'b0;
                pay_valid = 1'b0;
                clr_underrun = 1'b0;
                @(negedge clk);
                nRst = 1'b1;
                return;
            end
            clr_underrun = (t == clr_t);
            pay_valid = idx < pay_q.size() && t >= ready_at && !(idx == hold_idx && t < hold_t);
            pay_data = pay_valid ? pay_q[idx] : 8'($urandom);
            if (pay_valid && pay_ready) begin
                take_t.push_back(t);
                take_b.push_back(pay_q[idx]);
                idx++;
                ready_at = t + 1 + int'($urandom_range(jit, 0));
            end
        end
        pay_valid = 1'b0;
        model(pay, emp);
        exp_unr = 1'b0;
        for (int j = 0; j < NB; j++)
            if (emp[j] && 10 + 8 * j >= clr_t) exp_unr = 1'b1;
        for (int t = 0; t <= FL; t++) begin
            e_so[t] = (t == 0) ? 1'b0 : (t <= 8) ? addr[8 - t] : (t < 10) ? 1'b1 :
                      (t < 10 + PB) ? pay[PB - 1 - (t - 10)] : 1'b1;
            e_rr[t] = (t == FL);
            e_bz[t] = (t != FL);
        end
        chk({tag, " serial"}, so, e_so);
        chk({tag, " req_ready"}, rr, e_rr);
        chk({tag, " busy"}, bz, e_bz);
        chk({tag, " underrun_end"}, unr_end, exp_unr);
        chk({tag, " pay_ready_after_payload"}, pr_bad, 0);
        if (hold_idx < 0 && jit == 0) chk({tag, " bytes_taken"}, take_t.size(), NB);
        else chk({tag, " bytes_taken_limit"}, take_t.size() <= NB, 1);
        so_o = so;
    endtask

    initial begin
        logic [FL:0] so;
        logic [7:0] hb, rv, a;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {serial_out, busy, pay_ready, underrun}, 4'b1000);
        nRst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {req_ready, busy, pay_ready}, 3'b100);

        fill(NB + 3);
        start(8'hA5);
        run_frame(8'hA5, -1, 0, 0, -1, -1, 1'b0, "a5", so);
        chk("a5_header", so[9:0], 10'b1101001010);
        chk("a5_guard_high", so[FL:FL-2], 3'b111);

        fill(NB + 3);
        start(8'h3C);
        run_frame(8'h3C, -1, 0, 0, -1, -1, 1'b0, "3c", so);

        fill(NB + 3);
        a = 8'($urandom);
        start(a);
        run_frame(a, 3, 40, 0, -1, -1, 1'b0, "hold3", so);
        hb = pay_q[3];
        for (int k = 0; k < 8; k++) rv[k] = hb[7 - k];
        chk("hold3_zero_byte", so[41:34], 8'h00);
        chk("hold3_late_byte", so[49:42], rv);
        clear_unr("clear_after_hold3");

        fill(NB + 3);
        a = 8'($urandom);
        start(a);
        run_frame(a, 2, 36, 0, 26, -1, 1'b0, "coincident_clr", so);
        clear_unr("clear_after_coincident");

        for (int i = 0; i < 3; i++) begin
            fill(NB + 3);
            a = 8'($urandom);
            start(a);
            run_frame(a, -1, 0, 10, -1, -1, 1'b0, $sformatf("jitter%0d", i), so);
            clear_unr($sformatf("clear_after_jitter%0d", i));
        end

        a = 8'($urandom);
        fill(NB + 3);
        start(a);
        for (int i = 0; i < 3; i++) begin
            run_frame(a, -1, 0, 0, -1, -1, i < 2, $sformatf("b2b%0d", i), so);
            a = 8'($urandom);
            req_addr = a;
            fill(NB + 3);
        end

        fill(NB + 3);
        hb = pay_q[6];
        hb[5] = 1'b0;
        pay_q[6] = hb;
        start(8'h5A);
        run_frame(8'h5A, -1, 0, 0, -1, 60, 1'b0, "abort", so);
        fill(NB + 3);
        a = 8'($urandom);
        start(a);
        run_frame(a, -1, 0, 0, -1, -1, 1'b0, "post_abort", so);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
